// File: rtl/ultrasonic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ultrasonic_pkg : FSM encoding and timing helpers for the scanner      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_DONE      = 3'd4,
    S_HOLDOFF   = 3'd5
  } state_t;

  function automatic int unsigned cyc_per_us(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // Round-trip sound travel is ~58 us per cm of target distance.
  function automatic int unsigned cyc_per_cm(input int unsigned clk_hz);
    return 58 * cyc_per_us(clk_hz);
  endfunction

  function automatic int unsigned rise_to(input int unsigned clk_hz);
    return 1000 * cyc_per_us(clk_hz);
  endfunction

  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned CYC_PER_CM = cyc_per_cm(DEF_CLK_HZ);
  localparam int unsigned RISE_TO    = rise_to(DEF_CLK_HZ);

endpackage
`default_nettype wire

// File: rtl/us_cm_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | us_cm_counter : divider-free echo-time to centimetre converter        |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module us_cm_counter #(
  parameter int unsigned CYC_PER_CM = 2900,
  parameter int unsigned DIST_W     = 16,
  parameter int unsigned MAX_CM     = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_en,
  output logic [DIST_W-1:0] o_cm,
  output logic              o_max
);

  localparam int unsigned         c_pre_w    = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
  localparam logic [c_pre_w-1:0]  c_pre_last = c_pre_w'(CYC_PER_CM - 1);
  localparam logic [DIST_W-1:0]   c_max      = DIST_W'(MAX_CM);

  logic [c_pre_w-1:0] r_pre;
  logic [DIST_W-1:0]  r_cm;

  // The cm count saturates at the ceiling so a stuck echo cannot wrap it.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_pre <= '0;
      r_cm  <= '0;
    end else if (i_en && !o_max) begin
      if (r_pre == c_pre_last) begin
        r_pre <= '0;
        r_cm  <= r_cm + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign o_cm  = r_cm;
  assign o_max = (r_cm == c_max);

endmodule
`default_nettype wire

// File: rtl/ultrasonic_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ultrasonic_scanner : round-robin trigger/echo ranging over N_CH probes |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module ultrasonic_scanner
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DIST_W     = 16,
  parameter int unsigned MAX_CM     = 400,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned HOLDOFF_MS = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_CH-1:0]   echo,
  output logic [N_CH-1:0]   trigger,
  output logic [DIST_W-1:0] distance_cm,
  output logic [2:0]        channel,
  output logic              out_of_range,
  output logic              distance_ready
);

  localparam int unsigned       c_cyc_us    = cyc_per_us(CLK_HZ);
  localparam int unsigned       c_cyc_cm    = cyc_per_cm(CLK_HZ);
  localparam logic [31:0]       c_trig_last = 32'(TRIG_US * c_cyc_us - 1);
  localparam logic [31:0]       c_rise_last = 32'(rise_to(CLK_HZ) - 1);
  localparam logic [31:0]       c_hold_last = 32'(HOLDOFF_MS * 1000 * c_cyc_us - 1);
  localparam logic [DIST_W-1:0] c_max       = DIST_W'(MAX_CM);
  localparam logic [2:0]        c_last_ch   = 3'(N_CH - 1);

  if (MAX_CM == 0 || 64'(MAX_CM) >= (64'd1 << DIST_W)) begin : g_chk_max_cm
    $error("MAX_CM does not fit in DIST_W bits");
  end
  if (N_CH < 1 || N_CH > 8) begin : g_chk_n_ch
    $error("N_CH must be in 1..8");
  end
  if (c_cyc_us == 0 || TRIG_US == 0 || HOLDOFF_MS == 0) begin : g_chk_timing
    $error("CLK_HZ, TRIG_US and HOLDOFF_MS must give non-zero cycle counts");
  end

  state_t            r_state, w_next;
  logic [N_CH-1:0]   r_sync1, r_sync2, r_prev;
  logic [2:0]        r_ch;
  logic [31:0]       r_tmr;
  logic [N_CH-1:0]   r_trigger;
  logic [DIST_W-1:0] r_dist;
  logic [2:0]        r_chan;
  logic              r_oor, r_ready;

  logic              w_echo, w_echo_prev, w_rise;
  logic [N_CH-1:0]   w_trig_hot;
  logic              w_cnt_en, w_cnt_clr, w_cm_max, w_res_oor;
  logic [DIST_W-1:0] w_cm, w_res_cm;

  always_comb begin
    w_echo      = 1'b0;
    w_echo_prev = 1'b0;
    w_trig_hot  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_ch == 3'(i)) begin
        w_echo        = r_sync2[i];
        w_echo_prev   = r_prev[i];
        w_trig_hot[i] = 1'b1;
      end
    end
  end

  // r_prev carries the last TRIG-cycle level, so an echo already high on entry is no edge.
  assign w_rise    = w_echo & ~w_echo_prev;
  assign w_cnt_clr = (r_state == S_TRIG);

  us_cm_counter #(
    .CYC_PER_CM (c_cyc_cm),
    .DIST_W     (DIST_W),
    .MAX_CM     (MAX_CM)
  ) u_cm_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_cm    (w_cm),
    .o_max   (w_cm_max)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_en  = 1'b0;
    w_res_cm  = w_cm;
    w_res_oor = w_cm_max;
    case (r_state)
      S_IDLE:      if (enable) w_next = S_TRIG;
      S_TRIG:      if (r_tmr == c_trig_last) w_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (w_rise) begin
          w_next   = S_MEASURE;
          w_cnt_en = 1'b1;
        end else if (r_tmr == c_rise_last) begin
          w_next    = S_DONE;
          w_res_cm  = c_max;
          w_res_oor = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!w_echo || w_cm_max) w_next = S_DONE;
        else                     w_cnt_en = 1'b1;
      end
      S_DONE:      w_next = S_HOLDOFF;
      S_HOLDOFF:   if (r_tmr == c_hold_last) w_next = enable ? S_TRIG : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_ch      <= '0;
      r_tmr     <= '0;
      r_trigger <= '0;
      r_dist    <= '0;
      r_chan    <= '0;
      r_oor     <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_sync1   <= echo;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_state   <= w_next;
      r_tmr     <= (w_next != r_state) ? 32'd0 : r_tmr + 32'd1;
      r_trigger <= (w_next == S_TRIG) ? w_trig_hot : '0;
      r_ready   <= (w_next == S_DONE);
      if (w_next == S_DONE) begin
        r_dist <= w_res_cm;
        r_oor  <= w_res_oor;
        r_chan <= r_ch;
      end
      if (r_state == S_DONE) r_ch <= (r_ch == c_last_ch) ? 3'd0 : r_ch + 3'd1;
    end
  end

  assign trigger        = r_trigger;
  assign distance_cm    = r_dist;
  assign channel        = r_chan;
  assign out_of_range   = r_oor;
  assign distance_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ultrasonic_scanner : randomized self-checking bench for the scanner |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_ultrasonic_scanner;

  localparam int CLK_HZ     = 1_000_000;
  localparam int N_CH       = 4;
  localparam int DIST_W     = 16;
  localparam int MAX_CM     = 50;
  localparam int TRIG_US    = 10;
  localparam int HOLDOFF_MS = 1;
  localparam int CPU        = CLK_HZ / 1_000_000;
  localparam int CPC        = 58 * CPU;
  localparam int RISE       = 1000 * CPU;
  localparam int TRIGC      = TRIG_US * CPU;
  localparam int HOLDC      = HOLDOFF_MS * 1000 * CPU;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [N_CH-1:0]   echo = '0;
  logic [N_CH-1:0]   trigger;
  logic [DIST_W-1:0] distance_cm;
  logic [2:0]        channel;
  logic              out_of_range;
  logic              distance_ready;

  int errors = 0;
  int checks = 0;
  int exp_ch = 0;

  typedef struct {
    bit              trig_seen;
    int              gap;
    logic [N_CH-1:0] trig;
    int              width;
    bit              rdy_seen;
    int              lat;
    int              cm;
    logic            oor;
    int              ch;
    logic            rdy_after;
  } obs_t;

  ultrasonic_scanner #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .DIST_W(DIST_W),
    .MAX_CM(MAX_CM), .TRIG_US(TRIG_US), .HOLDOFF_MS(HOLDOFF_MS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trigger(trigger),
    .distance_cm(distance_cm), .channel(channel),
    .out_of_range(out_of_range), .distance_ready(distance_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference: echo of h cycles -> floor(h/CPC) cm, clipped at MAX_CM; no echo -> timeout.
  function automatic void model(input int h, output int cm, output bit oor);
    int c;
    if (h <= 0) begin cm = MAX_CM; oor = 1'b1; return; end
    c = h / CPC;
    if (c >= MAX_CM) begin cm = MAX_CM; oor = 1'b1; end
    else begin cm = c; oor = 1'b0; end
  endfunction

  function automatic logic [N_CH-1:0] onehot(input int c);
    logic [N_CH-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_trigger(input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n++;
      if (trigger != '0) seen = 1'b1;
    end
  endtask

  // Waits for a trigger, answers with an echo of h cycles on channel chn after dly
  // cycles (h<=0: no echo), with random activity on all other channels.
  task automatic run_measure(input int chn, input int h, input int dly, input int drop_t,
                             output obs_t o);
    logic [N_CH-1:0] e;
    o = '{default: 0};
    wait_trigger(HOLDC + 100, o.gap, o.trig_seen);
    if (!o.trig_seen) return;
    o.trig = trigger;
    while (trigger === o.trig && o.width < TRIGC + 20) begin
      o.width++;
      step();
    end
    for (int t = 0; t < dly + h + RISE + 200; t++) begin
      e = N_CH'($urandom);
      e[chn] = (h > 0 && t >= dly && t < dly + h);
      echo = e;
      if (t == drop_t) enable = 1'b0;
      step();
      if (distance_ready === 1'b1) begin
        o.rdy_seen = 1'b1;
        o.lat = t + 1;
        o.cm  = int'(distance_cm);
        o.oor = out_of_range;
        o.ch  = int'(channel);
        break;
      end
    end
    echo = '0;
    step();
    o.rdy_after = distance_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; echo = '1;
    repeat (4) step();
    checks++; if (trigger !== '0) begin errors++; $display("FAIL reset_trigger: got %b want 0", trigger); end
    checks++; if (distance_cm !== '0) begin errors++; $display("FAIL reset_dist: got %0d want 0", distance_cm); end
    checks++; if (channel !== 3'd0) begin errors++; $display("FAIL reset_channel: got %0d want 0", channel); end
    checks++; if (out_of_range !== 1'b0) begin errors++; $display("FAIL reset_oor: got %b want 0", out_of_range); end
    checks++; if (distance_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", distance_ready); end
    enable = 1'b0; echo = '0;
    step();
    rst = 1'b0;
    repeat (20) step();
    checks++; if (trigger !== '0) begin errors++; $display("FAIL idle_no_trigger: got %b want 0", trigger); end
    exp_ch = 0;
  endtask

  task automatic test_basic();
    obs_t o;
    enable = 1'b1;
    run_measure(exp_ch, 10 * CPC, 200, -1, o);
    checks++; if (!o.rdy_seen) begin errors++; $display("FAIL basic_ready: got none want strobe"); return; end
    checks++; if (o.gap !== 1) begin errors++; $display("FAIL basic_first_trig: got %0d cycles want 1", o.gap); end
    checks++; if (o.trig !== onehot(0)) begin errors++; $display("FAIL basic_trig: got %b want %b", o.trig, onehot(0)); end
    checks++; if (o.width !== TRIGC) begin errors++; $display("FAIL basic_width: got %0d want %0d", o.width, TRIGC); end
    checks++; if (o.cm !== 10) begin errors++; $display("FAIL basic_cm: got %0d want 10", o.cm); end
    checks++; if (o.ch !== 0) begin errors++; $display("FAIL basic_ch: got %0d want 0", o.ch); end
    checks++; if (o.oor !== 1'b0) begin errors++; $display("FAIL basic_oor: got %b want 0", o.oor); end
    checks++; if (o.rdy_after !== 1'b0) begin errors++; $display("FAIL basic_ready_len: got %b want 0", o.rdy_after); end
    exp_ch = (exp_ch + 1) % N_CH;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int   cms [5] = '{10, 20, 30, 40, 10};
    int   h, ecm;
    bit   eoor;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    exp_ch = 0;
    for (int k = 0; k < 5; k++) begin
      h = cms[k] * CPC + int'($urandom_range(0, CPC - 1));
      model(h, ecm, eoor);
      run_measure(exp_ch, h, int'($urandom_range(0, 300)), -1, o);
      checks++; if (!o.rdy_seen) begin errors++; $display("FAIL rr_ready[%0d]: got none want strobe", k); continue; end
      checks++; if (o.gap !== ((k == 0) ? 1 : HOLDC)) begin errors++; $display("FAIL rr_gap[%0d]: got %0d want %0d", k, o.gap, (k == 0) ? 1 : HOLDC); end
      checks++; if (o.trig !== onehot(exp_ch)) begin errors++; $display("FAIL rr_trig[%0d]: got %b want %b", k, o.trig, onehot(exp_ch)); end
      checks++; if (o.cm !== ecm) begin errors++; $display("FAIL rr_cm[%0d]: got %0d want %0d", k, o.cm, ecm); end
      checks++; if (o.ch !== exp_ch) begin errors++; $display("FAIL rr_ch[%0d]: got %0d want %0d", k, o.ch, exp_ch); end
      checks++; if (o.oor !== eoor) begin errors++; $display("FAIL rr_oor[%0d]: got %b want %b", k, o.oor, eoor); end
      exp_ch = (exp_ch + 1) % N_CH;
    end
  endtask

  task automatic test_boundary();
    obs_t o;
    int   hs [4] = '{CPC - 1, CPC, MAX_CM * CPC - 1, MAX_CM * CPC};
    int   ecm;
    bit   eoor;
    for (int k = 0; k < 4; k++) begin
      model(hs[k], ecm, eoor);
      run_measure(exp_ch, hs[k], 20, -1, o);
      checks++; if (!o.rdy_seen) begin errors++; $display("FAIL bnd_ready[%0d]: got none want strobe", k); continue; end
      checks++; if (o.width !== TRIGC) begin errors++; $display("FAIL bnd_width[%0d]: got %0d want %0d", k, o.width, TRIGC); end
      checks++; if (o.gap !== HOLDC) begin errors++; $display("FAIL bnd_holdoff[%0d]: got %0d want %0d", k, o.gap, HOLDC); end
      checks++; if (o.cm !== ecm) begin errors++; $display("FAIL bnd_cm[%0d]: got %0d want %0d", k, o.cm, ecm); end
      checks++; if (o.oor !== eoor) begin errors++; $display("FAIL bnd_oor[%0d]: got %b want %b", k, o.oor, eoor); end
      exp_ch = (exp_ch + 1) % N_CH;
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_measure(exp_ch, 0, 0, -1, o);
    checks++; if (!o.rdy_seen) begin errors++; $display("FAIL to_ready: got none want strobe"); end
    checks++; if (o.lat !== RISE) begin errors++; $display("FAIL to_latency: got %0d want %0d", o.lat, RISE); end
    checks++; if (o.cm !== MAX_CM) begin errors++; $display("FAIL to_cm: got %0d want %0d", o.cm, MAX_CM); end
    checks++; if (o.oor !== 1'b1) begin errors++; $display("FAIL to_oor: got %b want 1", o.oor); end
    checks++; if (o.ch !== exp_ch) begin errors++; $display("FAIL to_ch: got %0d want %0d", o.ch, exp_ch); end
    exp_ch = (exp_ch + 1) % N_CH;
    // Echo stuck high: result must arrive while the echo is still asserted.
    run_measure(exp_ch, MAX_CM * CPC + 2000, 40, -1, o);
    checks++; if (!o.rdy_seen) begin errors++; $display("FAIL held_ready: got none want strobe"); end
    checks++; if (o.lat !== 40 + MAX_CM * CPC + 3) begin errors++; $display("FAIL held_latency: got %0d want %0d", o.lat, 40 + MAX_CM * CPC + 3); end
    checks++; if (o.cm !== MAX_CM) begin errors++; $display("FAIL held_cm: got %0d want %0d", o.cm, MAX_CM); end
    checks++; if (o.oor !== 1'b1) begin errors++; $display("FAIL held_oor: got %b want 1", o.oor); end
    exp_ch = (exp_ch + 1) % N_CH;
  endtask

  task automatic test_random();
    obs_t o;
    int   h, ecm;
    bit   eoor;
    for (int k = 0; k < 6; k++) begin
      h = int'($urandom_range(1, MAX_CM * CPC + 300));
      model(h, ecm, eoor);
      run_measure(exp_ch, h, int'($urandom_range(0, 300)), -1, o);
      checks++; if (!o.rdy_seen) begin errors++; $display("FAIL rnd_ready[%0d]: got none want strobe (h=%0d)", k, h); continue; end
      checks++; if (o.cm !== ecm) begin errors++; $display("FAIL rnd_cm[%0d]: got %0d want %0d (h=%0d)", k, o.cm, ecm, h); end
      checks++; if (o.oor !== eoor) begin errors++; $display("FAIL rnd_oor[%0d]: got %b want %b (h=%0d)", k, o.oor, eoor, h); end
      checks++; if (o.ch !== exp_ch) begin errors++; $display("FAIL rnd_ch[%0d]: got %0d want %0d", k, o.ch, exp_ch); end
      exp_ch = (exp_ch + 1) % N_CH;
    end
  endtask

  task automatic test_enable_drop();
    obs_t o;
    int   n;
    bit   seen;
    run_measure(exp_ch, 1000, 50, 300, o);
    checks++; if (!o.rdy_seen) begin errors++; $display("FAIL drop_ready: got none want strobe"); end
    checks++; if (o.cm !== 1000 / CPC) begin errors++; $display("FAIL drop_cm: got %0d want %0d", o.cm, 1000 / CPC); end
    exp_ch = (exp_ch + 1) % N_CH;
    wait_trigger(HOLDC + 300, n, seen);
    checks++; if (seen) begin errors++; $display("FAIL drop_idle: got trigger %b after %0d cycles want none", trigger, n); end
    enable = 1'b1;
    run_measure(exp_ch, 300, 10, -1, o);
    checks++; if (o.gap !== 1) begin errors++; $display("FAIL drop_resume_gap: got %0d want 1", o.gap); end
    checks++; if (o.ch !== exp_ch) begin errors++; $display("FAIL drop_resume_ch: got %0d want %0d", o.ch, exp_ch); end
    checks++; if (o.cm !== 300 / CPC) begin errors++; $display("FAIL drop_resume_cm: got %0d want %0d", o.cm, 300 / CPC); end
    exp_ch = (exp_ch + 1) % N_CH;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   n, stray;
    bit   seen;
    wait_trigger(HOLDC + 100, n, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rmid_trigger: got none want trigger"); return; end
    n = 0;
    while (trigger != '0 && n < TRIGC + 20) begin n++; step(); end
    echo = onehot(exp_ch);
    repeat (400) step();
    rst = 1'b1; enable = 1'b0;
    step();
    checks++; if (trigger !== '0) begin errors++; $display("FAIL rmid_trigger_clr: got %b want 0", trigger); end
    checks++; if (distance_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b want 0", distance_ready); end
    checks++; if (distance_cm !== '0) begin errors++; $display("FAIL rmid_dist: got %0d want 0", distance_cm); end
    checks++; if (channel !== 3'd0) begin errors++; $display("FAIL rmid_channel: got %0d want 0", channel); end
    rst = 1'b0; echo = '0;
    stray = 0;
    for (int t = 0; t < 300; t++) begin
      step();
      if (distance_ready !== 1'b0 || trigger !== '0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_stale: got %0d active cycles want 0", stray); end
    exp_ch = 0;
    enable = 1'b1;
    run_measure(exp_ch, 2 * CPC, 10, -1, o);
    checks++; if (o.trig !== onehot(0)) begin errors++; $display("FAIL rmid_restart_trig: got %b want %b", o.trig, onehot(0)); end
    checks++; if (o.cm !== 2) begin errors++; $display("FAIL rmid_restart_cm: got %0d want 2", o.cm); end
    checks++; if (o.ch !== 0) begin errors++; $display("FAIL rmid_restart_ch: got %0d want 0", o.ch); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_boundary();
    test_timeout();
    test_random();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ultrasonic_scanner.md
ULTRASONIC_SCANNER -- requirements
Module: ultrasonic_scanner

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, meaning: clk frequency in Hz.
REQ-002 Parameter N_CH, default 4, meaning: number of sensor channels, 1..8.
REQ-003 Parameter DIST_W, default 16, meaning: width of the distance result in cm.
REQ-004 Parameter MAX_CM, default 400, meaning: range ceiling; an echo at or beyond it is reported as out of range.
REQ-005 Parameter TRIG_US, default 10, meaning: trigger pulse width in microseconds.
REQ-006 Parameter HOLDOFF_MS, default 60, meaning: quiet time after each measurement before the next trigger.
REQ-007 Derived constants SHALL be: CYC_PER_US = CLK_HZ/1_000_000; CYC_PER_CM = 58*CYC_PER_US (2900 at default); RISE_TO = 1000*CYC_PER_US.
REQ-008 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 enable  input  1  1 = scan channels continuously; 0 = stop after the current measurement.
REQ-011 echo  input  N_CH  asynchronous echo lines, one per channel.
REQ-012 trigger  output  N_CH  trigger lines; at most one bit SHALL be high at a time.
REQ-013 distance_cm  output  DIST_W  last result in cm.
REQ-014 channel  output  3  channel index of the last result.
REQ-015 out_of_range  output  1  last result timed out or reached MAX_CM.
REQ-016 distance_ready  output  1  one-cycle strobe marking a new result.

Function
REQ-017 Every echo bit SHALL pass through a 2-flop synchronizer; all echo decisions SHALL use the synchronized value.
REQ-018 The FSM SHALL have exactly six states:
  - IDLE: to TRIG when enable=1.
  - TRIG: trigger[ch] held high for TRIG_US*CYC_PER_US cycles, then to WAIT_RISE.
  - WAIT_RISE: to MEASURE on a synchronized 0->1 edge of echo[ch]; to DONE with timeout after RISE_TO cycles.
  - MEASURE: count cycles while echo[ch] is high; to DONE on the falling edge, or at MAX_CM.
  - DONE: outputs update, one cycle only.
  - HOLDOFF: wait HOLDOFF_MS*1000*CYC_PER_US cycles; then to TRIG if enable=1, else to IDLE.
REQ-019 Distance SHALL be computed without a divider:
  - a prescaler counts 0..CYC_PER_CM-1 during MEASURE;
  - on wrap it increments the cm counter;
  - result = floor(high_cycles / CYC_PER_CM).
REQ-020 If the cm counter reaches MAX_CM while echo is still high, the FSM SHALL leave MEASURE immediately; result = MAX_CM, out_of_range=1.
REQ-021 On a WAIT_RISE timeout the result SHALL be MAX_CM with out_of_range=1.
REQ-022 In DONE: distance_ready=1 for exactly one cycle; distance_cm, channel and out_of_range SHALL update in the same cycle and hold until the next DONE.
REQ-023 The channel index SHALL advance round-robin (N_CH-1 wraps to 0) on leaving DONE.
REQ-024 If enable falls mid-measurement, the measurement SHALL complete, including DONE and HOLDOFF, before entering IDLE.
REQ-025 An echo already high on entry to WAIT_RISE SHALL NOT count as a rising edge.
REQ-026 Echo activity on channels other than ch SHALL be ignored.
REQ-027 MAX_CM SHALL fit in DIST_W bits; a parameter check SHALL flag a violation at elaboration.

Reset
REQ-028 With rst=1 at a clock edge, the following SHALL take effect on that edge, including mid-operation:
  - state=IDLE; channel index=0;
  - trigger=0; distance_cm=0; channel=0; out_of_range=0; distance_ready=0;
  - all counters and synchronizer flops cleared.
REQ-029 After rst falls, the first trigger SHALL rise no earlier than the cycle after enable is sampled high.

Structure
REQ-030 The state encoding and the CYC_PER_CM / RISE_TO constants SHALL live in a shared package ultrasonic_pkg.
REQ-031 The prescaler plus cm counter SHALL be a sub-module us_cm_counter (clear, count enable, cm value, max reached).

Verification
REQ-032 Default params, enable=1; ch0 echo high 29000 cycles, starting 1000 cycles after trigger falls -> distance_cm=10, channel=0, out_of_range=0, one-cycle distance_ready.
REQ-033 Round-robin: echoes of 10, 20, 30, 40 cm on ch0..3 -> results 10, 20, 30, 40 with channel 0, 1, 2, 3, then channel wraps to 0.
REQ-034 Timeouts:
  - no echo on ch1 -> after RISE_TO cycles: distance_cm=400, out_of_range=1;
  - echo held high -> exit at 400 cm with out_of_range=1.
REQ-035 Boundary: echo 2899 cycles -> 0 cm; 2900 -> 1 cm; trigger width exactly 500 cycles; holdoff exactly 3,000,000 cycles.
REQ-036 Disturbances:
  - rst pulsed mid-MEASURE -> trigger=0, distance_ready=0 and no stale result;
  - enable dropped mid-MEASURE -> one more distance_ready, then IDLE with no trigger.
